// File: rtl/best_match_tracker.sv
// -----------------------------------------------------------------------------
// best_match_tracker
//
// Consumes one signed correlation sum per candidate offset of a raster-ordered
// SEARCH_W x SEARCH_H search window and keeps the candidate whose absolute sum
// is smallest. The earliest candidate in raster order wins a tie. When the last
// candidate has been compared, the winning offset and its cost are presented
// through a valid/ready handshake. The outputs stay frozen until the result is
// taken.
//
// Optional feature macro: BEST_MATCH_SECOND_BEST_EN
//   When this macro is defined, the block also tracks the second-smallest cost
//   and drives it on second_cost.
//
// Parameters
//   SUM_W     width of the signed input sum
//   SEARCH_W  number of candidate x offsets (>= 2)
//   SEARCH_H  number of candidate y offsets (>= 2)
//   X_W, Y_W  derived index widths
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   enable         global stall. Low freezes every register.
//   start          begins a search; honoured only when idle
//   sum_in         signed cost of the current candidate
//   sum_valid      sum_in is valid this cycle
//   busy           searching or holding a result
//   result_valid   result outputs are valid and stable
//   result_ready   downstream takes the result
//   best_x/best_y  index of the winning candidate
//   best_cost      |sum| of the winning candidate
//   second_cost    second-smallest cost (only with BEST_MATCH_SECOND_BEST_EN)
// -----------------------------------------------------------------------------
module best_match_tracker #(
    parameter int SUM_W    = 17,
    parameter int SEARCH_W = 8,
    parameter int SEARCH_H = 8,
    parameter int X_W      = $clog2(SEARCH_W),
    parameter int Y_W      = $clog2(SEARCH_H)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    start,
    input  logic signed [SUM_W-1:0] sum_in,
    input  logic                    sum_valid,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [X_W-1:0]          best_x,
    output logic [Y_W-1:0]          best_y,
`ifdef BEST_MATCH_SECOND_BEST_EN
    output logic [SUM_W-1:0]        second_cost,
`endif
    output logic [SUM_W-1:0]        best_cost
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [SUM_W-1:0] COST_MAX = {SUM_W{1'b1}};
    localparam logic [X_W-1:0]   X_LAST   = X_W'(SEARCH_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(SEARCH_H - 1);

    // The result is unsigned and has the same width as the input. This lets
    // the most negative input map to 2^(SUM_W-1) without wrapping.
    function automatic logic [SUM_W-1:0] abs_cost(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-1:0] r;
        if (v[SUM_W-1]) begin
            r = ~v + {{(SUM_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [X_W-1:0]   cand_x_q, cand_x_d;
    logic [Y_W-1:0]   cand_y_q, cand_y_d;
    logic [X_W-1:0]   best_x_q, best_x_d;
    logic [Y_W-1:0]   best_y_q, best_y_d;
    logic [SUM_W-1:0] best_cost_q, best_cost_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;
`ifdef BEST_MATCH_SECOND_BEST_EN
    logic [SUM_W-1:0] second_cost_q, second_cost_d;
`endif
    logic [SUM_W-1:0] cost_s;
    logic             last_cand_s;

    // Per-candidate cost and detection of the final raster position.
    always_comb begin
        cost_s      = abs_cost(sum_in);
        last_cand_s = (cand_x_q == X_LAST) && (cand_y_q == Y_LAST);
    end

    // Next-state logic for the control FSM, the candidate counters and the result.
    always_comb begin
        state_d        = state_q;
        cand_x_d       = cand_x_q;
        cand_y_d       = cand_y_q;
        best_x_d       = best_x_q;
        best_y_d       = best_y_q;
        best_cost_d    = best_cost_q;
        busy_d         = busy_q;
        result_valid_d = result_valid_q;
`ifdef BEST_MATCH_SECOND_BEST_EN
        second_cost_d  = second_cost_q;
`endif
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_SEARCH;
                        busy_d      = 1'b1;
                        cand_x_d    = {X_W{1'b0}};
                        cand_y_d    = {Y_W{1'b0}};
                        best_x_d    = {X_W{1'b0}};
                        best_y_d    = {Y_W{1'b0}};
                        best_cost_d = COST_MAX;
`ifdef BEST_MATCH_SECOND_BEST_EN
                        second_cost_d = COST_MAX;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    if (sum_valid) begin
                        // The comparison is strict, so on a tie the earlier candidate is kept.
                        if (cost_s < best_cost_q) begin
                            best_cost_d = cost_s;
                            best_x_d    = cand_x_q;
                            best_y_d    = cand_y_q;
`ifdef BEST_MATCH_SECOND_BEST_EN
                            second_cost_d = best_cost_q;
`endif
                        end else begin
`ifdef BEST_MATCH_SECOND_BEST_EN
                            // An equal cost that lost the tie can still become second best.
                            if (cost_s < second_cost_q) begin
                                second_cost_d = cost_s;
                            end else begin
                                second_cost_d = second_cost_q;
                            end
`else
                            best_cost_d = best_cost_q;
`endif
                        end
                        if (last_cand_s) begin
                            state_d        = ST_DONE;
                            result_valid_d = 1'b1;
                            cand_x_d       = {X_W{1'b0}};
                            cand_y_d       = {Y_W{1'b0}};
                        end else if (cand_x_q == X_LAST) begin
                            cand_x_d = {X_W{1'b0}};
                            cand_y_d = cand_y_q + {{(Y_W-1){1'b0}}, 1'b1};
                        end else begin
                            cand_x_d = cand_x_q + {{(X_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_DONE: begin
                    if (result_valid_q && result_ready) begin
                        state_d        = ST_IDLE;
                        result_valid_d = 1'b0;
                        busy_d         = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d        = ST_IDLE;
                    busy_d         = 1'b0;
                    result_valid_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers. rst discards any search in progress or result waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cand_x_q       <= {X_W{1'b0}};
            cand_y_q       <= {Y_W{1'b0}};
            best_x_q       <= {X_W{1'b0}};
            best_y_q       <= {Y_W{1'b0}};
            best_cost_q    <= COST_MAX;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef BEST_MATCH_SECOND_BEST_EN
            second_cost_q  <= COST_MAX;
`endif
        end else begin
            state_q        <= state_d;
            cand_x_q       <= cand_x_d;
            cand_y_q       <= cand_y_d;
            best_x_q       <= best_x_d;
            best_y_q       <= best_y_d;
            best_cost_q    <= best_cost_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
`ifdef BEST_MATCH_SECOND_BEST_EN
            second_cost_q  <= second_cost_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign best_x       = best_x_q;
    assign best_y       = best_y_q;
    assign best_cost    = best_cost_q;
`ifdef BEST_MATCH_SECOND_BEST_EN
    assign second_cost  = second_cost_q;
`endif

endmodule

// File: doc/best_match_tracker.md
# best_match_tracker

Downstream consumer of the 16×16 tree-adder output. It accepts one signed correlation sum per candidate offset in a raster-ordered search window and tracks the candidate with the smallest absolute sum. When the window is complete it reports the best offset and its cost through a valid/ready result handshake. The block sits between the tree adder and the frame-alignment / shift-and-add logic.

## Interface
- `SUM_W`, 17: width of the signed input sum; must match the tree-adder output width.
- `SEARCH_W`, 8: number of candidate x offsets; must be ≥2.
- `SEARCH_H`, 8: number of candidate y offsets; must be ≥2.
- `X_W`, `$clog2(SEARCH_W)`: derived; width of the x index.
- `Y_W`, `$clog2(SEARCH_H)`: derived; width of the y index.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: global stall. While low, all registers hold and every input except `rst` is ignored.
- `start` in 1: begins a new search. Accepted only in IDLE.
- `sum_in` in SUM_W, signed: cost for the current candidate.
- `sum_valid` in 1: `sum_in` is valid this cycle.
- `busy` out 1: high in SEARCH and DONE.
- `result_valid` out 1: the result is held stable while this is high.
- `result_ready` in 1: downstream accepts the result.
- `best_x` out X_W: x index of the winning candidate.
- `best_y` out Y_W: y index of the winning candidate.
- `best_cost` out SUM_W, unsigned: |sum| of the winning candidate.

## Operation
- The state machine has three states: IDLE, SEARCH, DONE.
- **IDLE → SEARCH** on `start`. On entry: `cand_x` and `cand_y` are cleared, `best_cost` is set to all ones, and `best_x`/`best_y` are set to 0.
- **SEARCH**
  - Each `sum_valid` cycle consumes one candidate at (`cand_x`, `cand_y`).
  - Cost = |`sum_in`|, computed as an SUM_W-bit unsigned value. The most negative input −2^(SUM_W−1) maps to 2^(SUM_W−1) without overflow.
  - If cost < `best_cost` (strictly less), `best_cost`, `best_x` and `best_y` are updated.
  - Ties keep the earlier candidate in raster order, so the first occurrence wins.
  - `cand_x` increments. At SEARCH_W−1 it wraps to 0 and `cand_y` increments.
  - The candidate at (SEARCH_W−1, SEARCH_H−1) is compared normally, and the state then moves to DONE.
- **DONE**
  - `result_valid` is high and the outputs are frozen.
  - The state moves to IDLE on the cycle `result_valid && result_ready` is sampled.
- Ignored inputs:
  - `start` in SEARCH or DONE has no effect.
  - `sum_valid` in IDLE or DONE is dropped and does not advance the counters.
- Gaps in `sum_valid` during SEARCH are allowed; the counters advance only on valid cycles.
- `rst` asserted at any point, including mid-search or while a result is pending, returns the block to IDLE immediately and discards the partial result.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `result_valid` 0;
  - `best_x` 0, `best_y` 0, `best_cost` all ones;
  - internal counters 0.
- `busy` rises the cycle after `start` is accepted.
- Latency: `result_valid` rises the cycle after the last candidate's `sum_valid` is sampled (1 clock).
- `result_valid` falls the cycle after the handshake completes. The earliest next `start` is accepted in the following cycle (in IDLE).
- A complete search takes at least 1 + SEARCH_W·SEARCH_H + 1 cycles when `enable` is held high.
- `enable` low stretches every phase cycle-for-cycle with no loss of state.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `BEST_MATCH_SECOND_BEST_EN`.
- **Defined:**
  - Adds output `second_cost` (SUM_W, unsigned), the second-smallest cost seen.
  - On a new best, the old best moves to `second_cost`.
  - Otherwise, if cost < `second_cost`, `second_cost` updates.
  - A cost equal to `best_cost` that does not replace it still qualifies as the new `second_cost` when it is smaller.
  - Reset and search-start value of `second_cost` is all ones. It is valid under the same handshake as the other result outputs.
- **Undefined:** the port and its logic are absent, and behaviour is otherwise identical.

## Test plan
- Window 4×4, with `sum_in` = 100 − 5·k for k = 0..15 → `best_x`=3, `best_y`=3, `best_cost`=25, with `result_valid` one cycle after the 16th valid.
- Window 4×4, with all sums = 40 except candidate (2,1) = −7 → `best_x`=2, `best_y`=1, `best_cost`=7.
- Tie: candidates (1,0) and (3,2) both −12, all others 50 → `best_x`=1, `best_y`=0 (first occurrence wins).
- Input −65536 at (0,0), all others 65535 → `best_cost`=65535 at (1,0). This checks the abs with no wrap, and 65536 is not selected.
- `result_ready` held low for 5 cycles with `start` pulsed during DONE → outputs stay stable and `start` is ignored. `rst` pulsed at candidate 9 of the next search → all outputs return to reset values.
- With `BEST_MATCH_SECOND_BEST_EN` defined, sums 30, 10, 20, 10, then 50 for the rest → `best_cost`=10 at (1,0), `second_cost`=10.
